// File: rtl/mips_multicycle_hs_pkg.sv
// Shared types and constants for the handshaked multicycle MIPS core.
// Holds the FSM state codes, the instruction classes, the ALU operations, the MIPS
// opcode/funct encodings and the instruction decoder (a pure function of IR).
package mips_multicycle_hs_pkg;

  typedef enum logic [2:0] {
    StFetchReq,
    StFetchWait,
    StDecode,
    StExecute,
    StMemWait,
    StWriteback,
    StFailure
  } state_e;

  typedef enum logic [2:0] {ItR, ItI, ItM, ItB, ItJ, ItJal, ItJr, ItBad} itype_e;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor,
    AluSlt, AluSltu, AluSll, AluSrl, AluSra, AluLui
  } alu_op_e;

  typedef struct packed {
    itype_e  itype;
    alu_op_e alu_op;
    logic    use_imm;   // ALU operand B is the immediate
    logic    zext_imm;  // logical immediates are zero-extended
    logic    is_store;
    logic    is_bne;
  } dec_t;

  localparam logic [5:0] OpRtype = 6'h00, OpJ    = 6'h02, OpJal  = 6'h03, OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05, OpAddi = 6'h08, OpAddiu = 6'h09, OpSlti = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b, OpAndi = 6'h0c, OpOri  = 6'h0d, OpXori  = 6'h0e;
  localparam logic [5:0] OpLui   = 6'h0f, OpLw   = 6'h23, OpSw   = 6'h2b;

  localparam logic [5:0] FnSll = 6'h00, FnSrl = 6'h02, FnSra = 6'h03, FnJr   = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20, FnAddu = 6'h21, FnSub = 6'h22, FnSubu = 6'h23;
  localparam logic [5:0] FnAnd = 6'h24, FnOr  = 6'h25, FnXor = 6'h26, FnNor  = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2a, FnSltu = 6'h2b;

  localparam logic [4:0] RegRa = 5'd31;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.itype    = ItBad;
    d.alu_op   = AluAdd;
    d.use_imm  = 1'b1;
    d.zext_imm = 1'b0;
    d.is_store = 1'b0;
    d.is_bne   = 1'b0;
    case (ir[31:26])
      OpRtype: begin
        d.itype   = ItR;
        d.use_imm = 1'b0;
        case (ir[5:0])
          FnSll:         d.alu_op = AluSll;
          FnSrl:         d.alu_op = AluSrl;
          FnSra:         d.alu_op = AluSra;
          FnJr:          d.itype  = ItJr;
          FnAdd, FnAddu: d.alu_op = AluAdd;
          FnSub, FnSubu: d.alu_op = AluSub;
          FnAnd:         d.alu_op = AluAnd;
          FnOr:          d.alu_op = AluOr;
          FnXor:         d.alu_op = AluXor;
          FnNor:         d.alu_op = AluNor;
          FnSlt:         d.alu_op = AluSlt;
          FnSltu:        d.alu_op = AluSltu;
          default:       d.itype  = ItBad;
        endcase
      end
      OpAddi, OpAddiu: d.itype = ItI;
      OpSlti:  begin d.itype = ItI; d.alu_op = AluSlt;  end
      OpSltiu: begin d.itype = ItI; d.alu_op = AluSltu; end
      OpAndi:  begin d.itype = ItI; d.alu_op = AluAnd; d.zext_imm = 1'b1; end
      OpOri:   begin d.itype = ItI; d.alu_op = AluOr;  d.zext_imm = 1'b1; end
      OpXori:  begin d.itype = ItI; d.alu_op = AluXor; d.zext_imm = 1'b1; end
      OpLui:   begin d.itype = ItI; d.alu_op = AluLui; end
      OpLw:    d.itype = ItM;
      OpSw:    begin d.itype = ItM; d.is_store = 1'b1; end
      OpBeq:   d.itype = ItB;
      OpBne:   begin d.itype = ItB; d.is_bne = 1'b1; end
      OpJ:     d.itype = ItJ;
      OpJal:   d.itype = ItJal;
      default: d.itype = ItBad;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_multicycle_hs_mem_port.sv
// Registered memory request port with bounded wait.
// start (one cycle, only while idle) captures wr/addr/wdata and raises mem_req on the next
// cycle. The request and its address/data hold until mem_ready is seen, then drop.
// done    : mem_req && mem_ready this cycle (read data valid now).
// timeout : TIMEOUT request cycles elapsed without ready; the request is abandoned.
// Ready in the same cycle as the timeout wins (done=1, timeout=0). TIMEOUT=0 disables it.
module mips_multicycle_hs_mem_port
  import mips_multicycle_hs_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         wr,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  input  logic         mem_ready,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  output logic         mem_wr_ena,
  output logic [N-1:0] mem_wr_data,
  output logic         done,
  output logic         timeout
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TimeoutEn = (TIMEOUT != 0);
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic            req_q, req_d;
  logic            wr_q, wr_d;
  logic [N-1:0]    addr_q, addr_d;
  logic [N-1:0]    wdata_q, wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign done    = req_q & mem_ready;
  // cnt_q counts request cycles already spent, so the last allowed one is CntLast.
  assign timeout = TimeoutEn & req_q & ~mem_ready & (cnt_q == CntLast);

  always_comb begin
    req_d   = req_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (start) begin
      req_d   = 1'b1;
      wr_d    = wr;
      addr_d  = addr;
      wdata_d = wdata;
      cnt_d   = '0;
    end else if (req_q) begin
      if (mem_ready || timeout) begin
        req_d = 1'b0;
        wr_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign mem_wr_ena  = wr_q;
  assign mem_wr_data = wdata_q;

endmodule

// File: rtl/mips_multicycle_hs.sv
// Multicycle MIPS core with a single shared (von Neumann) memory port using req/ready.
// Ports: clk/rst (async active-high), ena (sampled only in FETCH_REQ), mem_* handshake
// port, PC, flattened debug register file, instr_retired counter and sticky fault.
// Supports R-type ALU ops, I-type ALU ops, LW/SW, BEQ/BNE, J/JAL/JR. Illegal
// instructions and memory timeouts park the core in StFailure until reset.
module mips_multicycle_hs
  import mips_multicycle_hs_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic [N-1:0]      mem_addr,
  output logic              mem_wr_ena,
  output logic [N-1:0]      mem_wr_data,
  input  logic [N-1:0]      mem_rd_data,
  output logic [31:0]       PC,
  output logic [32*N-1:0]   full_register_file,
  output logic [CNT_W-1:0]  instr_retired,
  output logic              fault
);

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;
  logic [31:0]        btarget_q, btarget_d;
  logic [N-1:0]       dr_q, dr_d;
  logic [N-1:0]       reg_a_q, reg_a_d;
  logic [N-1:0]       reg_b_q, reg_b_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               fault_q, fault_d;
  logic [N-1:0]       rf_q [32];

  logic               rf_we;
  logic [4:0]         rf_waddr;
  logic [N-1:0]       rf_wdata;

  logic               mp_start, mp_wr, mp_done, mp_timeout;
  logic [N-1:0]       mp_addr, mp_wdata;

  dec_t               dec;
  logic [N-1:0]       sei, imm_ext, alu_b, alu_res;
  logic [4:0]         shamt;
  logic               alu_equal, br_taken;
  logic [31:0]        jtarget;

  assign dec       = decode(ir_q);
  assign sei       = {{(N-16){ir_q[15]}}, ir_q[15:0]};
  assign imm_ext   = dec.zext_imm ? {{(N-16){1'b0}}, ir_q[15:0]} : sei;
  assign alu_b     = dec.use_imm ? imm_ext : reg_b_q;
  assign shamt     = ir_q[10:6];
  assign alu_equal = (reg_a_q == reg_b_q);
  assign br_taken  = dec.is_bne ? ~alu_equal : alu_equal;
  assign jtarget   = {pc_q[31:28], ir_q[25:0], 2'b00};

  // ALU; shifts operate on rt as in MIPS, overflow is never trapped.
  always_comb begin
    alu_res = '0;
    case (dec.alu_op)
      AluAdd:  alu_res = reg_a_q + alu_b;
      AluSub:  alu_res = reg_a_q - alu_b;
      AluAnd:  alu_res = reg_a_q & alu_b;
      AluOr:   alu_res = reg_a_q | alu_b;
      AluXor:  alu_res = reg_a_q ^ alu_b;
      AluNor:  alu_res = ~(reg_a_q | alu_b);
      AluSlt:  alu_res = {{(N-1){1'b0}}, $signed(reg_a_q) < $signed(alu_b)};
      AluSltu: alu_res = {{(N-1){1'b0}}, reg_a_q < alu_b};
      AluSll:  alu_res = reg_b_q << shamt;
      AluSrl:  alu_res = reg_b_q >> shamt;
      AluSra:  alu_res = N'($signed(reg_b_q) >>> shamt);
      AluLui:  alu_res = {ir_q[15:0], {(N-16){1'b0}}};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    btarget_d = btarget_q;
    dr_d      = dr_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    mp_start  = 1'b0;
    mp_wr     = 1'b0;
    mp_addr   = N'(pc_q);
    mp_wdata  = reg_b_q;
    rf_we     = 1'b0;
    rf_waddr  = ir_q[20:16];
    rf_wdata  = alu_res;
    unique case (state_q)
      StFetchReq: begin
        if (ena) begin
          mp_start = 1'b1;
          state_d  = StFetchWait;
        end
      end
      StFetchWait: begin
        if (mp_done) begin
          ir_d    = mem_rd_data[31:0];
          pc_d    = pc_q + 32'd4;
          state_d = StDecode;
        end else if (mp_timeout) begin
          fault_d = 1'b1;
          state_d = StFailure;
        end
      end
      StDecode: begin
        reg_a_d   = rf_q[ir_q[25:21]];
        reg_b_d   = rf_q[ir_q[20:16]];
        btarget_d = pc_q + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        state_d   = StExecute;
      end
      StExecute: begin
        case (dec.itype)
          ItR, ItI: state_d = StWriteback;
          ItM: begin
            mp_start = 1'b1;
            mp_wr    = dec.is_store;
            mp_addr  = reg_a_q + sei;
            state_d  = StMemWait;
          end
          ItB: begin
            if (br_taken) pc_d = btarget_q;
            retired_d = retired_q + CNT_W'(1);
            state_d   = StFetchReq;
          end
          ItJ: begin
            pc_d      = jtarget;
            retired_d = retired_q + CNT_W'(1);
            state_d   = StFetchReq;
          end
          ItJal: begin
            // pc_q already holds the return address (PC+4).
            pc_d      = jtarget;
            rf_we     = 1'b1;
            rf_waddr  = RegRa;
            rf_wdata  = N'(pc_q);
            retired_d = retired_q + CNT_W'(1);
            state_d   = StFetchReq;
          end
          ItJr: begin
            pc_d      = 32'(reg_a_q);
            retired_d = retired_q + CNT_W'(1);
            state_d   = StFetchReq;
          end
          default: begin
            fault_d = 1'b1;
            state_d = StFailure;
          end
        endcase
      end
      StMemWait: begin
        if (mp_done) begin
          if (dec.is_store) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = StFetchReq;
          end else begin
            dr_d    = mem_rd_data;
            state_d = StWriteback;
          end
        end else if (mp_timeout) begin
          fault_d = 1'b1;
          state_d = StFailure;
        end
      end
      StWriteback: begin
        rf_we     = 1'b1;
        rf_waddr  = (dec.itype == ItR) ? ir_q[15:11] : ir_q[20:16];
        rf_wdata  = (dec.itype == ItM) ? dr_q : alu_res;
        retired_d = retired_q + CNT_W'(1);
        state_d   = StFetchReq;
      end
      StFailure: fault_d = 1'b1;
      default: begin
        fault_d = 1'b1;
        state_d = StFailure;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetchReq;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      btarget_q <= '0;
      dr_q      <= '0;
      reg_a_q   <= '0;
      reg_b_q   <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      btarget_q <= btarget_d;
      dr_q      <= dr_d;
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  // Register file; $0 is never written so it reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_rf_flat
    assign full_register_file[g*N +: N] = rf_q[g];
  end

  mips_multicycle_hs_mem_port #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) u_mem_port (
    .clk         (clk),
    .rst         (rst),
    .start       (mp_start),
    .wr          (mp_wr),
    .addr        (mp_addr),
    .wdata       (mp_wdata),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wr_ena  (mem_wr_ena),
    .mem_wr_data (mem_wr_data),
    .done        (mp_done),
    .timeout     (mp_timeout)
  );

  assign PC            = pc_q;
  assign instr_retired = retired_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_mips_multicycle_hs.sv
// Directed bench for mips_multicycle_hs: zero-wait ALU program, wait-state LW,
// branches, JAL/JR/J, memory timeout and async reset, ena parking around a SW,
// and an illegal opcode.
module tb_mips_multicycle_hs;

  localparam logic [31:0] ResetPc = 32'h0040_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          mem_req, mem_ready, mem_wr_ena, fault;
  logic [31:0]   mem_addr, mem_wr_data, mem_rd_data, pc, instr_retired;
  logic [1023:0] full_rf;

  logic [31:0] mem [256];
  int          wait_cfg = 0;
  bit          hang = 1'b0;
  int          wcnt = 0;
  logic [31:0] st_addr = '0, st_data = '0;
  int          st_cnt = 0;
  int          n_checks = 0, n_fail = 0;

  mips_multicycle_hs #(
    .N        (32),
    .RESET_PC (ResetPc),
    .TIMEOUT  (16),
    .CNT_W    (32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ena                (ena),
    .mem_req            (mem_req),
    .mem_ready          (mem_ready),
    .mem_addr           (mem_addr),
    .mem_wr_ena         (mem_wr_ena),
    .mem_wr_data        (mem_wr_data),
    .mem_rd_data        (mem_rd_data),
    .PC                 (pc),
    .full_register_file (full_rf),
    .instr_retired      (instr_retired),
    .fault              (fault)
  );

  always #5 clk = ~clk;

  // Code lives at 0x0040_xxxx (upper half), data at low addresses (lower half).
  function automatic int midx(input logic [31:0] a);
    return int'({a[22], a[8:2]});
  endfunction

  assign mem_ready   = mem_req && !hang && (wcnt == wait_cfg);
  assign mem_rd_data = mem[midx(mem_addr)];

  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_wr_ena) begin
      st_addr <= mem_addr;
      st_data <= mem_wr_data;
      st_cnt  <= st_cnt + 1;
    end
    wcnt <= (!mem_req || mem_ready) ? 0 : wcnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] rf(input int i);
    return full_rf[i*32 +: 32];
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[midx(a)] = w;
  endtask

  // Hold reset, then release on a falling edge; next rising edge is cycle 1.
  task automatic start_run(input int wcfg, input bit hng);
    rst = 1'b1;
    wait_cfg = wcfg;
    hang = hng;
    ena = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_retired(input int target, input string tag);
    int k;
    k = 0;
    while (instr_retired !== 32'(target) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(tag, instr_retired, 32'(target));
  endtask

  initial begin
    int k;

    // Reset values
    clear_mem();
    @(negedge clk);
    check("rst pc", pc, ResetPc);
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wr_ena", {31'd0, mem_wr_ena}, 32'd0);
    check("rst retired", instr_retired, 32'd0);
    check("rst fault", {31'd0, fault}, 32'd0);

    // 1: zero-wait ADDI chain, exact 5-cycle latency, $0 discard, ADD
    clear_mem();
    put(32'h0040_0000, enc_i(8, 0, 1, 5));
    put(32'h0040_0004, enc_i(8, 1, 2, -7));
    put(32'h0040_0008, enc_i(8, 0, 0, 3));
    put(32'h0040_000c, enc_r(1, 2, 9, 32'h20));
    start_run(0, 1'b0);
    tick(9);
    check("t1 retired@9", instr_retired, 32'd1);
    tick(1);
    check("t1 retired@10", instr_retired, 32'd2);
    check("t1 r1", rf(1), 32'd5);
    check("t1 r2", rf(2), 32'hFFFF_FFFE);
    wait_retired(4, "t1 retired 4");
    check("t1 r0", rf(0), 32'd0);
    check("t1 add r9", rf(9), 32'd3);

    // 2: LW with 3 wait cycles
    clear_mem();
    put(32'h0040_0000, enc_i(32'h23, 0, 3, 4));
    put(32'h0000_0004, 32'hDEAD_BEEF);
    start_run(3, 1'b0);
    k = 0;
    while (!(mem_req && mem_addr == 32'd4) && k < 100) begin
      @(negedge clk);
      k++;
    end
    for (int c = 0; c < 4; c++) begin
      check("t2 lw req held", {31'd0, mem_req}, 32'd1);
      check("t2 lw addr held", mem_addr, 32'd4);
      check("t2 lw not write", {31'd0, mem_wr_ena}, 32'd0);
      @(negedge clk);
    end
    check("t2 lw req drop", {31'd0, mem_req}, 32'd0);
    tick(1);
    check("t2 r3", rf(3), 32'hDEAD_BEEF);
    check("t2 retired", instr_retired, 32'd1);

    // 3: BEQ/BNE taken and not taken
    clear_mem();
    put(32'h0040_0000, enc_i(8, 0, 4, 9));
    put(32'h0040_0004, enc_i(8, 0, 5, 9));
    put(32'h0040_0008, enc_i(4, 4, 5, 2));
    put(32'h0040_0014, enc_i(5, 4, 5, 2));
    put(32'h0040_0018, enc_i(4, 4, 0, 5));
    put(32'h0040_001c, enc_i(5, 4, 0, -8));
    start_run(0, 1'b0);
    wait_retired(3, "t3 beq retired");
    check("t3 beq taken pc", pc, 32'h0040_0014);
    wait_retired(4, "t3 bne retired");
    check("t3 bne not taken pc", pc, 32'h0040_0018);
    wait_retired(5, "t3 beq2 retired");
    check("t3 beq not taken pc", pc, 32'h0040_001c);
    wait_retired(6, "t3 bne2 retired");
    check("t3 bne taken back pc", pc, 32'h0040_0000);

    // 4: JAL / JR / J
    clear_mem();
    put(32'h0040_0008, enc_j(3, 32'h0100010));
    put(32'h0040_0040, enc_r(31, 0, 0, 32'h08));
    put(32'h0040_000c, enc_j(2, 32'h0100020));
    start_run(0, 1'b0);
    wait_retired(3, "t4 jal retired");
    check("t4 jal pc", pc, 32'h0040_0040);
    check("t4 jal r31", rf(31), 32'h0040_000C);
    wait_retired(4, "t4 jr retired");
    check("t4 jr pc", pc, 32'h0040_000C);
    wait_retired(5, "t4 j retired");
    check("t4 j pc", pc, 32'h0040_0080);

    // 5: timeout after 16 request cycles, then async reset mid-wait
    clear_mem();
    start_run(0, 1'b1);
    tick(1);
    check("t5 req cycle 1", {31'd0, mem_req}, 32'd1);
    tick(15);
    check("t5 req cycle 16", {31'd0, mem_req}, 32'd1);
    check("t5 no fault yet", {31'd0, fault}, 32'd0);
    tick(1);
    check("t5 fault set", {31'd0, fault}, 32'd1);
    check("t5 req dropped", {31'd0, mem_req}, 32'd0);
    tick(4);
    check("t5 fault sticky", {31'd0, fault}, 32'd1);
    check("t5 req stays low", {31'd0, mem_req}, 32'd0);
    start_run(0, 1'b1);
    tick(3);
    check("t5 mid-wait req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5 async rst req", {31'd0, mem_req}, 32'd0);
    check("t5 async rst pc", pc, ResetPc);
    check("t5 async rst fault", {31'd0, fault}, 32'd0);
    @(negedge clk);

    // 6: ena dropped during SW; store completes, core parks, resumes at PC+4
    clear_mem();
    put(32'h0040_0000, enc_i(8, 0, 7, 32'h55));
    put(32'h0040_0004, enc_i(32'h2b, 0, 7, 8));
    put(32'h0040_0008, enc_i(8, 0, 8, 1));
    start_run(2, 1'b0);
    k = 0;
    while (!(mem_req && mem_wr_ena) && k < 100) begin
      @(negedge clk);
      k++;
    end
    ena = 1'b0;
    check("t6 sw seen", {31'd0, mem_req & mem_wr_ena}, 32'd1);
    check("t6 sw addr", mem_addr, 32'd8);
    check("t6 sw data", mem_wr_data, 32'h55);
    wait_retired(2, "t6 sw retired");
    check("t6 store count", 32'(st_cnt), 32'd1);
    check("t6 store addr", st_addr, 32'd8);
    check("t6 store data", st_data, 32'h55);
    tick(6);
    check("t6 parked req", {31'd0, mem_req}, 32'd0);
    check("t6 parked retired", instr_retired, 32'd2);
    check("t6 parked pc", pc, 32'h0040_0008);
    ena = 1'b1;
    k = 0;
    while (!mem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t6 resume fetch addr", mem_addr, 32'h0040_0008);
    wait_retired(3, "t6 resume retired");
    check("t6 r8", rf(8), 32'd1);

    // 7: illegal opcode
    clear_mem();
    put(32'h0040_0000, 32'hFC00_0000);
    start_run(0, 1'b0);
    tick(6);
    check("t7 illegal fault", {31'd0, fault}, 32'd1);
    check("t7 illegal req", {31'd0, mem_req}, 32'd0);
    check("t7 illegal retired", instr_retired, 32'd0);
    check("t7 illegal pc", pc, 32'h0040_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
